// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid: upstream/downstream valid-ready pairs,
// payloads, flush control and status. slave = the stage, master = its environment.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    logic              flush_i;
    logic              up_valid_i;
    logic              up_ready_o;
    logic [DATA_W-1:0] up_data_i;
    logic              dn_valid_o;
    logic              dn_ready_i;
    logic [DATA_W-1:0] dn_data_o;
    logic [1:0]        occupancy_o;
    logic [CNT_W-1:0]  flush_drop_cnt_o;

    modport slave (
        input  flush_i, up_valid_i, up_data_i, dn_ready_i,
        output up_ready_o, dn_valid_o, dn_data_o, occupancy_o, flush_drop_cnt_o
    );

    modport master (
        output flush_i, up_valid_i, up_data_i, dn_ready_i,
        input  up_ready_o, dn_valid_o, dn_data_o, occupancy_o, flush_drop_cnt_o
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline register with registered up_ready, synchronous
// flush and a saturating count of entries discarded by flushes.
module pipe_stage_skid #(
    parameter int DATA_W         = 32,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CNT_W          = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    pipe_stage_skid_if.slave  bus
);
    // Encoding chosen so dn_valid is bit 0 and ~up_ready is bit 1 of the state flop.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W+1:0]  cnt_sum;
    logic [1:0]        dropped;
    logic              up_ready, dn_valid, up_fire, dn_fire;

    assign up_fire = bus.up_valid_i & up_ready;
    assign dn_fire = dn_valid & bus.dn_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush_i) begin
            state_d = EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (up_fire) begin
                        main_d  = bus.up_data_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (up_fire && dn_fire) begin
                        main_d = bus.up_data_i;
                    end else if (up_fire) begin
                        skid_d  = bus.up_data_i;
                        state_d = FULL;
                    end else if (dn_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (dn_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        dn_valid        = state_q[0];
        up_ready        = ~state_q[1];
        bus.dn_valid_o  = dn_valid;
        bus.up_ready_o  = up_ready;
        bus.dn_data_o   = main_q;
        bus.occupancy_o = {state_q[1], state_q[0] & ~state_q[1]};
    end

    // A main entry leaving via dn_fire during a flush counts as delivered, not dropped.
    always_comb begin
        dropped = 2'(dn_valid & ~bus.dn_ready_i) + 2'(state_q[1]) + 2'(up_fire);
        cnt_sum = {2'b00, cnt_q} + (CNT_W+2)'(dropped);
        cnt_d   = (cnt_sum > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)         cnt_q <= '0;
        else if (bus.flush_i) cnt_q <= cnt_d;
    end

    assign bus.flush_drop_cnt_o = cnt_q;
endmodule
